// File: rtl/yarp_decode_stage.sv
// Registered instruction-decode stage for the yarp core: decodes the fetched word
// combinationally and delivers results through a 2-entry skid buffer (main + skid).
module yarp_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     in_instr_i,
  input  logic [XLEN-1:0] in_pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_pc_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [6:0]      op_o,
  output logic [2:0]      funct3_o,
  output logic [6:0]      funct7_o,
  output logic [XLEN-1:0] imm_o,
  output logic            r_type_o,
  output logic            i_type_o,
  output logic            s_type_o,
  output logic            b_type_o,
  output logic            u_type_o,
  output logic            j_type_o,
  output logic            w_op_o,
  output logic            illegal_o
);

  localparam logic [5:0] FMT_R = 6'b100000;
  localparam logic [5:0] FMT_I = 6'b010000;
  localparam logic [5:0] FMT_S = 6'b001000;
  localparam logic [5:0] FMT_B = 6'b000100;
  localparam logic [5:0] FMT_U = 6'b000010;
  localparam logic [5:0] FMT_J = 6'b000001;

  // The raw word is kept so the field outputs come straight from storage.
  typedef struct packed {
    logic [XLEN-1:0]        pc;
    logic [31:0]            instr;
    logic signed [XLEN-1:0] imm;
    logic [5:0]             fmt;
    logic                   w_op;
    logic                   illegal;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] instr, input logic [XLEN-1:0] pc);
    dec_t               d;
    logic               f7_ok;
    logic signed [11:0] i12;
    logic signed [11:0] s12;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    logic signed [31:0] u32;
    d       = '0;
    d.pc    = pc;
    d.instr = instr;
    f7_ok   = (instr[31:25] == 7'b0000000) || (instr[31:25] == 7'b0100000);
    i12     = instr[31:20];
    s12     = {instr[31:25], instr[11:7]};
    b13     = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    j21     = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    u32     = {instr[31:12], 12'h000};
    case (instr[6:0])
      7'b0110011: if (f7_ok) d.fmt = FMT_R;
      7'b0111011: if (XLEN == 64 && f7_ok) begin d.fmt = FMT_R; d.w_op = 1'b1; end
      7'b0010011, 7'b0000011, 7'b1110011: d.fmt = FMT_I;
      7'b1100111: if (instr[14:12] == 3'b000) d.fmt = FMT_I;
      7'b0011011: if (XLEN == 64) begin d.fmt = FMT_I; d.w_op = 1'b1; end
      7'b0100011: d.fmt = FMT_S;
      7'b1100011: d.fmt = FMT_B;
      7'b0110111, 7'b0010111: d.fmt = FMT_U;
      7'b1101111: d.fmt = FMT_J;
      default: d.fmt = '0;
    endcase
    d.illegal = (instr[1:0] != 2'b11) || (d.fmt == '0);
    if (d.illegal) begin
      d.fmt  = '0;
      d.w_op = 1'b0;
    end
    case (d.fmt)
      FMT_I:   d.imm = XLEN'(i12);
      FMT_S:   d.imm = XLEN'(s12);
      FMT_B:   d.imm = XLEN'(b13);
      FMT_J:   d.imm = XLEN'(j21);
      FMT_U:   d.imm = XLEN'(u32);
      default: d.imm = '0;
    endcase
    return d;
  endfunction

  // Stage p0: combinational decode of the incoming word
  dec_t dec_p0;
  logic accept_p0;
  logic drain_p0;

  dec_t m_p1;
  dec_t s_p1;
  logic vld_p1;
  logic skid_vld_p1;

  assign dec_p0    = decode(in_instr_i, in_pc_i);
  assign accept_p0 = in_valid_i && !skid_vld_p1 && !flush_i;
  assign drain_p0  = vld_p1 && out_ready_i;

  // Stage p1: main/skid storage; the skid slot only fills while main is stalled
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      m_p1        <= '0;
      s_p1        <= '0;
    end else if (skid_vld_p1) begin
      if (drain_p0) begin
        m_p1        <= s_p1;
        skid_vld_p1 <= 1'b0;
      end
    end else if (vld_p1) begin
      if (accept_p0 && drain_p0) begin
        m_p1 <= dec_p0;
      end else if (accept_p0) begin
        s_p1        <= dec_p0;
        skid_vld_p1 <= 1'b1;
      end else if (drain_p0) begin
        vld_p1 <= 1'b0;
      end
    end else if (accept_p0) begin
      m_p1   <= dec_p0;
      vld_p1 <= 1'b1;
    end
  end

  assign in_ready_o  = !skid_vld_p1;
  assign out_valid_o = vld_p1;
  assign out_pc_o    = m_p1.pc;
  assign rs1_o       = m_p1.instr[19:15];
  assign rs2_o       = m_p1.instr[24:20];
  assign rd_o        = m_p1.instr[11:7];
  assign op_o        = m_p1.instr[6:0];
  assign funct3_o    = m_p1.instr[14:12];
  assign funct7_o    = m_p1.instr[31:25];
  assign imm_o       = m_p1.imm;
  assign {r_type_o, i_type_o, s_type_o, b_type_o, u_type_o, j_type_o} = m_p1.fmt;
  assign w_op_o      = m_p1.w_op;
  assign illegal_o   = m_p1.illegal;

endmodule

// File: doc/yarp_decode_stage.md
# yarp_decode_stage

Registered, handshaked instruction-decode pipeline stage for the yarp core. It replaces the purely combinational decode path between fetch and execute. It accepts one fetched instruction and its PC per cycle through a valid/ready interface and decodes register indices, opcode fields, the instruction-format one-hot and the XLEN-wide immediate. It adds RV64 opcodes, illegal-instruction detection and flush, and delivers results through a 2-entry skid buffer so neither side needs combinational ready paths.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64; immediates sign-extend to XLEN
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high
- flush_i  input  1  discard every buffered instruction this cycle
- in_valid_i  input  1  fetch presents instruction
- in_ready_o  input-side ready  output  1  stage can accept
- in_instr_i  input  32  raw instruction word
- in_pc_i  input  XLEN  PC of instruction
- out_valid_o  output  1  decoded instruction available
- out_ready_i  input  1  execute accepts
- out_pc_o  output  XLEN  PC carried through
- rs1_o / rs2_o / rd_o  output  5 each  instr[19:15] / [24:20] / [11:7]
- op_o  output  7  instr[6:0]
- funct3_o  output  3  instr[14:12]
- funct7_o  output  7  instr[31:25]
- imm_o  output  XLEN  decoded immediate
- r_type_o, i_type_o, s_type_o, b_type_o, u_type_o, j_type_o  output  1 each  format one-hot
- w_op_o  output  1  RV64 32-bit-word op (OP-32/OP-IMM-32); always 0 when XLEN=32
- illegal_o  output  1  instruction not decodable

## Operation
- Format map: 0110011 R; 0010011, 0000011, 1100111, 1110011 I; 0100011 S; 1100011 B; 0110111, 0010111 U; 1101111 J.
- XLEN=64 only: 0111011 R with w_op_o=1; 0011011 I with w_op_o=1. For XLEN=32 these opcodes are illegal.
- Immediates:
  - I: sext(instr[31:20])
  - S: sext({[31:25],[11:7]})
  - B: sext({[31],[7],[30:25],[11:8],0})
  - J: sext({[31],[19:12],[20],[30:21],0})
  - U: sext({[31:12],12'h0}) to XLEN
  - R and illegal: 0
- illegal_o=1 when any of the following holds:
  - instr[1:0]≠11
  - opcode not in the map
  - R-type funct7 ∉ {0000000, 0100000}
  - 1100111 with funct3≠000
- For an illegal instruction, all type flags are 0 and w_op_o is 0. The field outputs (rs1..funct7) still reflect the raw bits.
- Decode is combinational on the input word. The result is captured into storage on acceptance; outputs come only from storage.
- Storage: main register M (drives outputs) plus skid register S, each with a valid bit.
  - in_ready_o = !S.valid (registered, no combinational path from out_ready_i).
  - out_valid_o = M.valid.
  - Accept = in_valid_i && in_ready_o && !flush_i.
  - Drain = M.valid && out_ready_i.
- State transitions (count = M.valid+S.valid):
  - EMPTY → ONE on accept.
  - ONE: accept & drain → ONE (M loads new); accept & !drain → FULL (new goes to S); drain only → EMPTY.
  - FULL: drain → ONE (M←S); no accept possible.
- FIFO order is always preserved.
- flush_i: next state EMPTY regardless of other inputs. A concurrent input is dropped, a concurrent drain still completes at the handshake, and flush then clears storage.
- Reset: same as flush. All valid bits and every output are 0: out_valid_o=0, in_ready_o=1 (from the first cycle after reset), data outputs 0.

## Timing
- Latency: instruction accepted at edge N is on the outputs with out_valid_o=1 after edge N; it can be consumed in cycle N+1.
- Throughput: 1 instr/cycle while out_ready_i=1.
- When the stage is full, in_ready_o falls the cycle after the second unconsumed accept. It rises the cycle after the first drain.
- Outputs hold stable while out_valid_o=1 && !out_ready_i.
- Reset or flush asserted mid-stream is effective at the next edge; no partial state remains.

## Test plan
- XLEN=32, 0xFFF10093 (addi x1,x2,-1) → i_type_o=1, rd=1, rs1=2, imm_o=0xFFFFFFFF, out_valid_o one cycle after accept.
- 0x00112223 (sw x1,4(x2)) → s_type_o=1, imm=0x4. 0xFE000EE3 (beq x0,x0,-4) → b_type_o=1, imm=0xFFFFFFFC.
- XLEN=64: 0x800002B7 (lui x5,0x80000) → u_type_o=1, imm=0xFFFFFFFF80000000. 0x0000009B → i_type_o=1, w_op_o=1. The same word with XLEN=32 → illegal_o=1.
- 0x00000000 → illegal_o=1, all type flags 0. 0x40000033 → r_type_o=1. 0x20000033 → illegal_o=1.
- Backpressure: hold out_ready_i=0 and present PCs 0x0, 0x4, 0x8 → only two accepted, in_ready_o=0. Release → outputs 0x0 then 0x4 on consecutive cycles, then 0x8 accepted. Order and data are intact.
- Flush and reset with FULL storage plus a concurrent input → next cycle out_valid_o=0, in_ready_o=1, the concurrent input is never emitted.
